// File: rtl/secure_register_initiator.sv
// secure_register_initiator: screens thread-tagged requests and sequences permitted ones onto a thread-0-only register
module secure_register_initiator #(
   parameter int DATA_WIDTH = 32,
   parameter int TID_WIDTH  = 4,
   parameter int VIOL_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [TID_WIDTH-1:0]  req_tid,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  reg_access_en,
   output logic                  reg_wr_en,
   output logic                  reg_thread_id,
   output logic [DATA_WIDTH-1:0] reg_data_in,
   input  logic [DATA_WIDTH-1:0] reg_data_out,
   output logic                  locked,
   output logic [7:0]            viol_count
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [7:0] LIMIT = 8'(VIOL_LIMIT);
   state_t     state, state_nxt;
   logic       wr_q;
   logic       accept;
   logic       permit;
   logic       deny_tid;
   logic [7:0] viol_nxt;
   assign accept   = (state == IDLE) && req_valid;
   assign permit   = (req_tid == '0) && !locked;
   assign deny_tid = accept && (req_tid != '0);
   assign viol_nxt = (deny_tid && viol_count != 8'hFF) ? viol_count + 8'd1 : viol_count;
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   // next-state: permitted requests take the ISSUE/WAIT path, denials jump straight to RESP
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  state_nxt = req_valid ? (permit ? ISSUE : RESP) : IDLE;
         ISSUE: state_nxt = WAIT;
         WAIT:  state_nxt = RESP;
         RESP:  state_nxt = rsp_ready ? IDLE : RESP;
      endcase
   end
   // handshake and register-pin controls decoded straight from the state register
   always_comb begin
      req_ready     = state == IDLE;
      rsp_valid     = state == RESP;
      reg_access_en = state == ISSUE;
      reg_wr_en     = (state == ISSUE) && wr_q;
      reg_thread_id = state != ISSUE;
   end
   // request latch; write data only reaches the register pins for permitted requests
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q        <= 1'b0;
         reg_data_in <= '0;
      end else if (accept) begin
         wr_q <= req_write;
         if (permit) reg_data_in <= req_wdata;
      end
   end
   // response payload: loaded from the register for reads, error on denial, cleared once consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (state == WAIT) begin
         rsp_rdata <= wr_q ? '0 : reg_data_out;
         rsp_err   <= 1'b0;
      end else if (accept && !permit) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end
   end
   // saturating violation counter with sticky lockout once the limit is reached
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         viol_count <= 8'd0;
         locked     <= 1'b0;
      end else begin
         viol_count <= viol_nxt;
         locked     <= locked | (viol_nxt >= LIMIT);
      end
   end
endmodule
